// File: rtl/zero_run_expander_pkg.sv
// Shared definitions for the zero-run expander: default element width and
// the 2-bit FSM state encoding used by the top level.
package zero_run_expander_pkg;

    localparam int ZRE_DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        ZRE_IDLE  = 2'd0,
        ZRE_ZEROS = 2'd1,
        ZRE_VALUE = 2'd2,
        ZRE_FILL  = 2'd3
    } zre_state_t;

    // States whose emitted element is an inserted zero
    function automatic logic zre_is_zero_state(input zre_state_t s);
        return (s == ZRE_ZEROS) || (s == ZRE_FILL);
    endfunction

endpackage

// File: rtl/zre_stats_counter.sv
// Saturating 32-bit event counter with a synchronous clear that wins over
// increment. Used for the optional statistics outputs of zero_run_expander.
module zre_stats_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [31:0] count
);

    // Count events, stick at all-ones, clear on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != 32'hFFFF_FFFF)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/zero_run_expander.sv
// zero_run_expander: expands sparse (run, value, last) tokens into a dense,
// tile-framed element stream by re-inserting the skipped zeros.
// Optional feature macro: ZRE_STATS_EN adds stats_clr, stat_zeros and
// stat_values (saturating beat counters for inserted zeros and values).
module zero_run_expander
    import zero_run_expander_pkg::*;
#(
    parameter int DATA_WIDTH = ZRE_DATA_WIDTH,
    parameter int RUN_WIDTH  = 8,
    parameter int TILE_LEN   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [RUN_WIDTH-1:0]  run_in,
    input  logic                  last_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic                  last_out,
    output logic                  zero_flag,
    output logic                  err_overflow
`ifdef ZRE_STATS_EN
    ,
    input  logic                  stats_clr,
    output logic [31:0]           stat_zeros,
    output logic [31:0]           stat_values
`endif
);

    localparam int                   POS_W    = $clog2(TILE_LEN);
    localparam logic [POS_W-1:0]     POS_LAST = POS_W'(TILE_LEN - 1);
    localparam logic [POS_W-1:0]     POS_ONE  = POS_W'(1);
    localparam logic [RUN_WIDTH-1:0] RUN_ONE  = RUN_WIDTH'(1);

    zre_state_t            state_reg, state_next;
    logic [POS_W-1:0]      pos_reg, pos_next;
    logic [DATA_WIDTH-1:0] val_reg, val_next;
    logic [RUN_WIDTH-1:0]  run_reg, run_next;
    logic                  last_reg, last_next;
    logic                  err_reg, err_next;

    logic                  beat;
    logic                  pos_at_end;
    logic [POS_W-1:0]      pos_inc;

    // Every non-idle state presents an element, so a beat is just ready_out there
    assign beat       = (state_reg != ZRE_IDLE) && ready_out;
    assign pos_at_end = (pos_reg == POS_LAST);
    assign pos_inc    = pos_at_end ? '0 : (pos_reg + POS_ONE);

    // Outputs decode registered state only; no input-to-output paths
    assign ready_in     = (state_reg == ZRE_IDLE);
    assign valid_out    = (state_reg != ZRE_IDLE);
    assign data_out     = (state_reg == ZRE_VALUE) ? val_reg : '0;
    assign zero_flag    = zre_is_zero_state(state_reg);
    assign last_out     = valid_out && pos_at_end;
    assign err_overflow = err_reg;

    // State, position and token registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ZRE_IDLE;
            pos_reg   <= '0;
            val_reg   <= '0;
            run_reg   <= '0;
            last_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pos_reg   <= pos_next;
            val_reg   <= val_next;
            run_reg   <= run_next;
            last_reg  <= last_next;
            err_reg   <= err_next;
        end
    end

    // Next-state logic: token accept, zero run, value, end-of-tile fill
    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        val_next   = val_reg;
        run_next   = run_reg;
        last_next  = last_reg;
        err_next   = err_reg;

        case (state_reg)
            ZRE_IDLE: begin
                if (valid_in) begin
                    val_next   = data_in;
                    run_next   = run_in;
                    last_next  = last_in;
                    state_next = (run_in != '0) ? ZRE_ZEROS : ZRE_VALUE;
                end
            end
            ZRE_ZEROS: begin
                if (beat) begin
                    pos_next = pos_inc;
                    if (pos_at_end && (run_reg > RUN_ONE)) begin
                        // Run does not fit in the tile: close the tile and drop the token
                        err_next   = 1'b1;
                        run_next   = '0;
                        val_next   = '0;
                        state_next = ZRE_IDLE;
                    end else begin
                        run_next = run_reg - RUN_ONE;
                        if (run_reg == RUN_ONE) begin
                            state_next = ZRE_VALUE;
                        end
                    end
                end
            end
            ZRE_VALUE: begin
                if (beat) begin
                    pos_next   = pos_inc;
                    state_next = (last_reg && !pos_at_end) ? ZRE_FILL : ZRE_IDLE;
                end
            end
            ZRE_FILL: begin
                if (beat) begin
                    pos_next = pos_inc;
                    if (pos_at_end) begin
                        state_next = ZRE_IDLE;
                    end
                end
            end
            default: begin
                state_next = ZRE_IDLE;
            end
        endcase
    end

`ifdef ZRE_STATS_EN
    // Index 0 counts inserted-zero beats, index 1 counts value beats
    logic [1:0]  stat_inc;
    logic [31:0] stat_cnt [2];

    assign stat_inc[0] = beat && zre_is_zero_state(state_reg);
    assign stat_inc[1] = beat && (state_reg == ZRE_VALUE);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stat
            zre_stats_counter u_cnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (stats_clr),
                .inc   (stat_inc[gi]),
                .count (stat_cnt[gi])
            );
        end
    endgenerate

    assign stat_zeros  = stat_cnt[0];
    assign stat_values = stat_cnt[1];
`endif

endmodule

// File: tb/tb_zero_run_expander.sv
// Scoreboard bench for zero_run_expander (TILE_LEN=8): directed scenarios
// followed by random tokens, checked against a tile-level reference model.
module tb_zero_run_expander;

    localparam int DW = 16;
    localparam int RW = 8;
    localparam int TL = 8;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic [RW-1:0] run_in;
    logic          last_in;
    logic          valid_in;
    logic          ready_in;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_out;
    logic          last_out;
    logic          zero_flag;
    logic          err_overflow;
`ifdef ZRE_STATS_EN
    logic          stats_clr;
    logic [31:0]   stat_zeros;
    logic [31:0]   stat_values;
`endif

    zero_run_expander #(
        .DATA_WIDTH (DW),
        .RUN_WIDTH  (RW),
        .TILE_LEN   (TL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .run_in       (run_in),
        .last_in      (last_in),
        .valid_in     (valid_in),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .ready_out    (ready_out),
        .last_out     (last_out),
        .zero_flag    (zero_flag),
        .err_overflow (err_overflow)
`ifdef ZRE_STATS_EN
        ,
        .stats_clr    (stats_clr),
        .stat_zeros   (stat_zeros),
        .stat_values  (stat_values)
`endif
    );

    typedef struct packed {
        logic [DW-1:0] d;
        logic          z;
        logic          l;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          mpos  = 0;      // model tile position
    logic        exp_err = 1'b0; // model sticky overflow
    int          rmode = 0;      // 0: ready, 1: toggle, 2: random
    logic        mon_en = 1'b0;
    int          beat_cnt = 0;
    logic        stall_pending = 1'b0;
    logic [DW+2:0] held;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic z);
        exp_t e;
        e.d = d;
        e.z = z;
        e.l = (mpos == TL - 1);
        exp_q.push_back(e);
        mpos = (mpos + 1) % TL;
    endtask

    // Reference: run zeros, then the value, then zero-fill to tile end if last.
    // A run that would cross the tile boundary ends the tile and drops the token.
    task automatic model_token(input int run, input logic [DW-1:0] v, input logic last);
        int remaining = run;
        while (remaining > 0) begin
            if ((mpos == TL - 1) && (remaining > 1)) begin
                push_exp('0, 1'b1);
                exp_err = 1'b1;
                return;
            end
            push_exp('0, 1'b1);
            remaining--;
        end
        push_exp(v, 1'b0);
        if (last && (mpos != 0)) begin
            int fill = TL - mpos;
            for (int k = 0; k < fill; k++) push_exp('0, 1'b1);
        end
    endtask

    task automatic send_token(input int run, input logic [DW-1:0] v, input logic last);
        int n = 0;
        model_token(run, v, last);
        @(negedge clk);
        while (!ready_in && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready_in) begin
            check("ready_in_timeout", 32'(ready_in), 32'd1);
            return;
        end
        data_in  = v;
        run_in   = RW'(run);
        last_in  = last;
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        @(negedge clk);
        check("accept_next_cycle", 32'({valid_out, ready_in}), 32'b10);
        $display("token run=%0d val=0x%0h last=%0d", run, v, last);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        check({name, "_idle_after"}, 32'({ready_in, valid_out}), 32'b10);
        check({name, "_err_overflow"}, 32'(err_overflow), 32'(exp_err));
    endtask

    // Downstream ready pattern, changed just after each rising edge
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: ready_out = 1'b1;
            1: ready_out = ~ready_out;
            default: ready_out = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: stall stability and scoreboard comparison of every beat
    always @(negedge clk) begin
        if (!mon_en || !rst_n) begin
            stall_pending = 1'b0;
        end else begin
            if (stall_pending)
                check("stall_hold", 32'({valid_out, data_out, zero_flag, last_out}), 32'(held));
            stall_pending = valid_out && !ready_out;
            held = {valid_out, data_out, zero_flag, last_out};
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("beat", 32'({data_out, zero_flag, last_out}), 32'({e.d, e.z, e.l}));
                    $display("beat %0d data=0x%0h zf=%0d last=%0d", beat_cnt, data_out, zero_flag, last_out);
                    beat_cnt++;
                end
            end
        end
    end

    initial begin
        int start;
        int n;
        rst_n     = 1'b0;
        data_in   = '0;
        run_in    = '0;
        last_in   = 1'b0;
        valid_in  = 1'b0;
        ready_out = 1'b1;
`ifdef ZRE_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_outputs",
              32'({ready_in, valid_out, data_out, last_out, zero_flag, err_overflow}),
              32'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}));
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Basic tile: 0,0,5,7 then fill
        rmode = 0;
        send_token(2, 16'h0005, 1'b0);
        send_token(0, 16'h0007, 1'b1);
        drain("basic");
`ifdef ZRE_STATS_EN
        check("stat_zeros", stat_zeros, 32'd6);
        check("stat_values", stat_values, 32'd2);
        stats_clr = 1'b1;
        @(posedge clk);
        #1 stats_clr = 1'b0;
        @(negedge clk);
        check("stat_clr", 32'({stat_zeros[15:0], stat_values[15:0]}), 32'd0);
`endif

        // Same stimulus with downstream stalling every other cycle
        rmode = 1;
        send_token(2, 16'h0005, 1'b0);
        send_token(0, 16'h0007, 1'b1);
        drain("toggle");

        // Full tile of values, position wraps
        rmode = 0;
        for (int i = 1; i <= 8; i++) send_token(0, DW'(i), 1'b0);
        drain("dense");

        // Run that overflows the tile, then a token that must start at pos 0
        send_token(10, 16'h0003, 1'b0);
        drain("overflow");
        send_token(1, 16'h0044, 1'b1);
        drain("after_overflow");

        // Reset in the middle of a fill
        start = beat_cnt;
        send_token(0, 16'h0009, 1'b1);
        n = 0;
        while (beat_cnt < start + 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reach_fill", 32'(beat_cnt - start >= 3), 32'd1);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midfill_reset_outputs",
              32'({ready_in, valid_out, data_out, last_out, zero_flag, err_overflow}),
              32'({1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0}));
        exp_q.delete();
        mpos    = 0;
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        send_token(0, 16'h0011, 1'b1);
        drain("after_reset");

        // Random tokens with random backpressure
        rmode = 2;
        for (int i = 0; i < 40; i++) begin
            int r;
            logic [DW-1:0] v;
            r = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12));
            v = ($urandom_range(0, 5) == 0) ? '0 : DW'($urandom);
            send_token(r, v, ($urandom_range(0, 3) == 0));
        end
        drain("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
